// File: rtl/clock_monitor_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// clock_monitor_if : monitored clocks, controls and status of clock_monitor
// Revision 1.0
// ============================================================================

interface clock_monitor_if #(
    parameter int CNT_W = 12
);
    logic             lsi_clk;
    logic             wdt_clk;
    logic             lsi_mon_en;
    logic             wdt_mon_en;
    logic             fault_clr;
    logic [CNT_W-1:0] lsi_period;
    logic [CNT_W-1:0] wdt_period;
    logic             lsi_ok;
    logic             wdt_ok;
    logic [1:0]       lsi_fault;
    logic [1:0]       wdt_fault;
    logic             fault_irq;

    modport master (
        output lsi_clk, wdt_clk, lsi_mon_en, wdt_mon_en, fault_clr,
        input  lsi_period, wdt_period, lsi_ok, wdt_ok, lsi_fault, wdt_fault, fault_irq
    );

    modport slave (
        input  lsi_clk, wdt_clk, lsi_mon_en, wdt_mon_en, fault_clr,
        output lsi_period, wdt_period, lsi_ok, wdt_ok, lsi_fault, wdt_fault, fault_irq
    );
endinterface

`default_nettype wire

// File: rtl/clock_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// clock_monitor : period / range / stuck checker for the lsi and wdt clocks
// Revision 1.0
// ============================================================================

module clock_monitor_ch #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 12,
    parameter int PER_MIN     = 8,
    parameter int PER_MAX     = 12,
    parameter int TIMEOUT     = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mon_clk_i,
    input  logic             en_i,
    input  logic             fault_clr_i,
    output logic [CNT_W-1:0] period_o,
    output logic             ok_o,
    output logic [1:0]       fault_o
);
    typedef enum logic [2:0] {
        S_DISABLED   = 3'd0,
        S_WAIT_FIRST = 3'd1,
        S_MEASURE    = 3'd2,
        S_RUN        = 3'd3,
        S_FAULT      = 3'd4
    } state_t;

    localparam logic [1:0]       C_NONE    = 2'b00;
    localparam logic [1:0]       C_STUCK   = 2'b01;
    localparam logic [1:0]       C_FAST    = 2'b10;
    localparam logic [1:0]       C_SLOW    = 2'b11;
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_MIN     = CNT_W'(PER_MIN);
    localparam logic [CNT_W-1:0] C_MAX     = CNT_W'(PER_MAX);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [1:0]             fault_q, fault_d;
    logic                   rise;
    logic                   timeout;
    logic [CNT_W-1:0]       meas;
    logic [1:0]             range_code;
    logic [1:0]             new_code;

    // Sync depth must be at least 2; stage 0 is the metastable capture flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mon_clk_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign timeout = (cnt_q == C_TIMEOUT);
    // Doubles as the saturating counter increment and the measured period.
    assign meas    = (cnt_q == C_CNT_MAX) ? C_CNT_MAX : cnt_q + CNT_W'(1);

    always_comb begin
        range_code = C_NONE;
        if (meas < C_MIN) begin
            range_code = C_FAST;
        end else if (meas > C_MAX) begin
            range_code = C_SLOW;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_DISABLED;
            cnt_q    <= '0;
            period_q <= '0;
            fault_q  <= C_NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = rise ? '0 : meas;
        period_d = period_q;
        fault_d  = fault_q;
        new_code = C_NONE;

        case (state_q)
            S_DISABLED: begin
                cnt_d = '0;
                if (en_i) begin
                    state_d = S_WAIT_FIRST;
                end
            end
            S_WAIT_FIRST: begin
                if (timeout) begin
                    new_code = C_STUCK;
                end else if (rise) begin
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE, S_RUN: begin
                if (timeout) begin
                    new_code = C_STUCK;
                end else if (rise) begin
                    period_d = meas;
                    new_code = range_code;
                    if (range_code == C_NONE) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_FAULT: begin
                if (timeout) begin
                    new_code = C_STUCK;
                end else if (rise) begin
                    period_d = meas;
                    new_code = range_code;
                end
                // Re-arm restarts the count so a stale count cannot skip the timeout.
                if (fault_clr_i && (new_code == C_NONE)) begin
                    state_d = S_WAIT_FIRST;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_DISABLED;
            end
        endcase

        // A detection in the clear cycle survives the clear with its own cause.
        if (new_code != C_NONE) begin
            state_d = S_FAULT;
            if ((fault_q == C_NONE) || fault_clr_i) begin
                fault_d = new_code;
            end
        end else if (fault_clr_i) begin
            fault_d = C_NONE;
        end

        if (!en_i) begin
            state_d = S_DISABLED;
            cnt_d   = '0;
            fault_d = fault_clr_i ? C_NONE : fault_q;
        end
    end

    assign period_o = period_q;
    assign ok_o     = (state_q == S_RUN);
    assign fault_o  = fault_q;
endmodule

module clock_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 12,
    parameter int LSI_MIN     = 8,
    parameter int LSI_MAX     = 12,
    parameter int LSI_TIMEOUT = 24,
    parameter int WDT_MIN     = 18,
    parameter int WDT_MAX     = 22,
    parameter int WDT_TIMEOUT = 44
) (
    input  logic           clk,
    input  logic           reset,
    clock_monitor_if.slave mon
);
    logic fault_irq_q;

    clock_monitor_ch #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W),
        .PER_MIN     (LSI_MIN),
        .PER_MAX     (LSI_MAX),
        .TIMEOUT     (LSI_TIMEOUT)
    ) u_lsi (
        .clk         (clk),
        .reset       (reset),
        .mon_clk_i   (mon.lsi_clk),
        .en_i        (mon.lsi_mon_en),
        .fault_clr_i (mon.fault_clr),
        .period_o    (mon.lsi_period),
        .ok_o        (mon.lsi_ok),
        .fault_o     (mon.lsi_fault)
    );

    clock_monitor_ch #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W),
        .PER_MIN     (WDT_MIN),
        .PER_MAX     (WDT_MAX),
        .TIMEOUT     (WDT_TIMEOUT)
    ) u_wdt (
        .clk         (clk),
        .reset       (reset),
        .mon_clk_i   (mon.wdt_clk),
        .en_i        (mon.wdt_mon_en),
        .fault_clr_i (mon.fault_clr),
        .period_o    (mon.wdt_period),
        .ok_o        (mon.wdt_ok),
        .fault_o     (mon.wdt_fault)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_irq_q <= 1'b0;
        end else begin
            fault_irq_q <= (mon.lsi_fault != 2'b00) || (mon.wdt_fault != 2'b00);
        end
    end

    assign mon.fault_irq = fault_irq_q;
endmodule

`default_nettype wire

// File: tb/tb_clock_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_clock_monitor : scoreboard bench for clock_monitor, directed clock shapes
// Revision 1.0
// ============================================================================

module tb_clock_monitor;
    localparam int SEL_LPER = 0;
    localparam int SEL_WPER = 1;
    localparam int SEL_LOK  = 2;
    localparam int SEL_WOK  = 3;
    localparam int SEL_LF   = 4;
    localparam int SEL_WF   = 5;
    localparam int SEL_IRQ  = 6;

    typedef struct {
        int    at;
        string name;
        int    sel;
        int    val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    exp_t sb[$];

    // Source clock generator state: index 0 = lsi, 1 = wdt; half period in clk cycles.
    int half[2]     = '{5, 10};
    int ph[2]       = '{0, 0};
    bit run[2]      = '{1'b0, 1'b0};
    bit lvl[2]      = '{1'b0, 1'b0};
    int rise_cnt[2] = '{0, 0};
    int fall_cnt[2] = '{0, 0};
    int rise_cyc[2] = '{0, 0};

    clock_monitor_if #(.CNT_W(12)) mon_if ();

    clock_monitor #(
        .SYNC_STAGES (2),
        .CNT_W       (12),
        .LSI_MIN     (8),
        .LSI_MAX     (12),
        .LSI_TIMEOUT (24),
        .WDT_MIN     (18),
        .WDT_MAX     (22),
        .WDT_TIMEOUT (44)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (mon_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        mon_if.lsi_clk = 1'b0;
        mon_if.wdt_clk = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            for (int c = 0; c < 2; c++) begin
                if (run[c]) begin
                    ph[c] = ph[c] + 1;
                    if (ph[c] >= half[c]) begin
                        ph[c]  = 0;
                        lvl[c] = ~lvl[c];
                        if (lvl[c]) begin
                            rise_cnt[c] = rise_cnt[c] + 1;
                            rise_cyc[c] = cyc;
                        end else begin
                            fall_cnt[c] = fall_cnt[c] + 1;
                        end
                    end
                end
            end
            mon_if.lsi_clk = lvl[0];
            mon_if.wdt_clk = lvl[1];
        end
    end

    function automatic string sel_name(input int sel);
        case (sel)
            SEL_LPER: return "lsi_period";
            SEL_WPER: return "wdt_period";
            SEL_LOK:  return "lsi_ok";
            SEL_WOK:  return "wdt_ok";
            SEL_LF:   return "lsi_fault";
            SEL_WF:   return "wdt_fault";
            default:  return "fault_irq";
        endcase
    endfunction

    function automatic int actual(input int sel);
        case (sel)
            SEL_LPER: return int'(mon_if.lsi_period);
            SEL_WPER: return int'(mon_if.wdt_period);
            SEL_LOK:  return int'(mon_if.lsi_ok);
            SEL_WOK:  return int'(mon_if.wdt_ok);
            SEL_LF:   return int'(mon_if.lsi_fault);
            SEL_WF:   return int'(mon_if.wdt_fault);
            default:  return int'(mon_if.fault_irq);
        endcase
    endfunction

    task automatic expect_at(input int at, input string name, input int sel, input int val);
        sb.push_back('{at, name, sel, val});
    endtask

    // Monitor: every negedge, compare entries due this cycle; overdue entries fail.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at == cyc) begin
                    total = total + 1;
                    if (actual(sb[i].sel) == sb[i].val) begin
                        passed = passed + 1;
                    end else begin
                        $display("FAIL %s/%s cycle %0d: got %0d, expected %0d",
                                 sb[i].name, sel_name(sb[i].sel), cyc,
                                 actual(sb[i].sel), sb[i].val);
                    end
                    sb.delete(i);
                end else if (sb[i].at < cyc) begin
                    total = total + 1;
                    $display("FAIL %s/%s overdue: due cycle %0d, now %0d",
                             sb[i].name, sel_name(sb[i].sel), sb[i].at, cyc);
                    sb.delete(i);
                end
            end
        end
    end

    task automatic wait_edge(input int ch, input bit rising, output int p);
        int start;
        start = rising ? rise_cnt[ch] : fall_cnt[ch];
        p = -1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #4;
            if ((rising ? rise_cnt[ch] : fall_cnt[ch]) != start) begin
                p = cyc;
                break;
            end
        end
        if (p < 0) begin
            total = total + 1;
            $display("FAIL edge_wait ch=%0d rising=%0d: got no edge, expected one within 400 cycles",
                     ch, rising);
            p = cyc;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_all_zero(input int at, input string name);
        for (int s = 0; s <= SEL_IRQ; s++) expect_at(at, name, s, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 200 us");
        $fatal(1, "global timeout");
    end

    initial begin
        int p;
        int q;
        int n;
        reset             = 1'b1;
        mon_if.lsi_mon_en = 1'b0;
        mon_if.wdt_mon_en = 1'b0;
        mon_if.fault_clr  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_all_zero(cyc + 1, "reset");
        @(negedge clk);
        reset             = 1'b0;
        mon_if.lsi_mon_en = 1'b1;
        mon_if.wdt_mon_en = 1'b1;
        run[0]            = 1'b1;
        run[1]            = 1'b1;

        // Nominal lock: 100 ns lsi, 200 ns wdt.
        repeat (3) wait_edge(0, 1'b1, p);
        expect_at(p + 3, "lock", SEL_LPER, 10);
        expect_at(p + 3, "lock", SEL_LOK, 1);
        expect_at(p + 3, "lock", SEL_LF, 0);
        repeat (3) wait_edge(1, 1'b1, q);
        expect_at(q + 3, "lock", SEL_WPER, 20);
        expect_at(q + 3, "lock", SEL_WOK, 1);
        expect_at(q + 3, "lock", SEL_WF, 0);
        expect_at(q + 3, "lock", SEL_IRQ, 0);

        // Stop lsi: last rise seen by the DUT at p+3, stuck fault when cnt reaches 24.
        wait_edge(0, 1'b1, p);
        run[0] = 1'b0;
        expect_at(p + 27, "stuck_pre", SEL_LF, 0);
        expect_at(p + 27, "stuck_pre", SEL_LOK, 1);
        expect_at(p + 28, "stuck", SEL_LF, 1);
        expect_at(p + 28, "stuck", SEL_LOK, 0);
        expect_at(p + 28, "stuck", SEL_IRQ, 0);
        expect_at(p + 29, "stuck_irq", SEL_IRQ, 1);
        expect_at(p + 29, "stuck_wdt", SEL_WOK, 1);
        expect_at(p + 29, "stuck_wdt", SEL_WF, 0);
        wait_until(p + 30);

        // Clear and restart lsi at 100 ns.
        n                = cyc;
        mon_if.fault_clr = 1'b1;
        ph[0]            = 0;
        half[0]          = 5;
        run[0]           = 1'b1;
        expect_at(n + 1, "clr_stuck", SEL_LF, 0);
        expect_at(n + 2, "clr_stuck", SEL_IRQ, 0);
        @(negedge clk);
        mon_if.fault_clr = 1'b0;
        repeat (3) wait_edge(0, 1'b1, p);
        expect_at(p + 3, "relock", SEL_LOK, 1);

        // 60 ns then 160 ns periods: fast fault, code stays sticky.
        half[0] = 3;
        wait_edge(0, 1'b1, p);
        expect_at(p + 3, "fast", SEL_LPER, 6);
        expect_at(p + 3, "fast", SEL_LF, 2);
        expect_at(p + 3, "fast", SEL_LOK, 0);
        half[0] = 8;
        wait_edge(0, 1'b1, p);
        expect_at(p + 3, "sticky", SEL_LPER, 16);
        expect_at(p + 3, "sticky", SEL_LF, 2);
        expect_at(p + 3, "sticky", SEL_IRQ, 1);
        half[0] = 5;
        wait_until(p + 4);
        mon_if.fault_clr = 1'b1;
        expect_at(p + 5, "clr_fast", SEL_LF, 0);
        @(negedge clk);
        mon_if.fault_clr = 1'b0;
        repeat (2) wait_edge(0, 1'b1, p);
        expect_at(p + 3, "relock2", SEL_LPER, 10);
        expect_at(p + 3, "relock2", SEL_LOK, 1);
        expect_at(p + 3, "relock2", SEL_LF, 0);

        // wdt at 240 ns: slow fault; clear collides with the next slow rise.
        wait_edge(1, 1'b1, q);
        half[1] = 12;
        wait_edge(1, 1'b1, q);
        expect_at(q + 3, "slow", SEL_WPER, 24);
        expect_at(q + 3, "slow", SEL_WF, 3);
        expect_at(q + 3, "slow", SEL_WOK, 0);
        wait_until(q + 26);
        mon_if.fault_clr = 1'b1;
        expect_at(q + 27, "clr_vs_fault", SEL_WF, 3);
        expect_at(q + 27, "clr_vs_fault", SEL_WPER, 24);
        @(negedge clk);
        mon_if.fault_clr = 1'b0;
        expect_at(cyc + 1, "clr_vs_fault_hold", SEL_WF, 3);
        expect_at(cyc + 1, "clr_vs_fault_hold", SEL_IRQ, 1);
        half[1] = 10;
        wait_edge(1, 1'b1, q);
        wait_until(q + 4);
        mon_if.fault_clr = 1'b1;
        expect_at(q + 5, "clr_slow", SEL_WF, 0);
        @(negedge clk);
        mon_if.fault_clr = 1'b0;
        repeat (2) wait_edge(1, 1'b1, q);
        expect_at(q + 3, "wdt_relock", SEL_WPER, 20);
        expect_at(q + 3, "wdt_relock", SEL_WOK, 1);
        expect_at(q + 3, "wdt_relock", SEL_WF, 0);
        expect_at(q + 3, "wdt_relock", SEL_IRQ, 0);

        // Disabled lsi with a dead clock for 1000 cycles, then re-enabled.
        @(negedge clk);
        mon_if.lsi_mon_en = 1'b0;
        run[0]            = 1'b0;
        repeat (1000) @(negedge clk);
        expect_at(cyc + 1, "disabled", SEL_LF, 0);
        expect_at(cyc + 1, "disabled", SEL_LOK, 0);
        @(negedge clk);
        n                 = cyc;
        mon_if.lsi_mon_en = 1'b1;
        expect_at(n + 25, "enable_wait", SEL_LF, 0);
        expect_at(n + 26, "enable_stuck", SEL_LF, 1);
        expect_at(n + 27, "enable_stuck", SEL_IRQ, 1);
        wait_until(n + 28);

        // Relock lsi, park both sources low, then a short reset pulse between edges.
        mon_if.fault_clr = 1'b1;
        ph[0]            = 0;
        run[0]           = 1'b1;
        @(negedge clk);
        mon_if.fault_clr = 1'b0;
        repeat (3) wait_edge(0, 1'b1, p);
        expect_at(p + 3, "pre_reset", SEL_LOK, 1);
        wait_edge(1, 1'b0, q);
        run[1] = 1'b0;
        wait_edge(0, 1'b0, p);
        run[0] = 1'b0;
        @(negedge clk);
        expect_all_zero(cyc + 1, "async_reset");
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        ph[0]  = 0;
        ph[1]  = 0;
        run[0] = 1'b1;
        run[1] = 1'b1;
        repeat (3) wait_edge(0, 1'b1, p);
        expect_at(p + 3, "post_reset", SEL_LPER, 10);
        expect_at(p + 3, "post_reset", SEL_LOK, 1);
        expect_at(p + 3, "post_reset", SEL_LF, 0);
        repeat (3) wait_edge(1, 1'b1, q);
        expect_at(q + 3, "post_reset", SEL_WPER, 20);
        expect_at(q + 3, "post_reset", SEL_WOK, 1);
        expect_at(q + 3, "post_reset", SEL_WF, 0);
        expect_at(q + 3, "post_reset", SEL_IRQ, 0);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            total = total + 1;
            $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

`default_nettype wire
